// File: rtl/ssp_rx_logic.sv
// Receive side of the TI synchronous-serial port: samples SSPRXD on falling
// SSPCLKIN edges seen in the PCLK domain and writes completed words to the RX FIFO.
module ssp_rx_logic #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  reset,
  input  logic                  SSPCLKIN,
  input  logic                  SSPFSSIN,
  input  logic                  SSPRXD,
  input  logic                  RxFull,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  RxWrite,
  output logic                  RxOverrun,
  output logic                  RxBusy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  generate
    if (DATA_WIDTH < 4 || DATA_WIDTH > 16) begin : g_bad_width
      $error("ssp_rx_logic: DATA_WIDTH must be within 4..16");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                  state_q,      state_d;
  logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q,      shreg_d;
  logic [DATA_WIDTH-1:0]   rx_data_q,    rx_data_d;
  logic                    clkin_q,      clkin_d;
  logic                    rx_write_q,   rx_write_d;
  logic                    rx_overrun_q, rx_overrun_d;
  logic                    rx_busy_q,    rx_busy_d;

  logic                    fall;
  logic [DATA_WIDTH-1:0]   word;

  // Falling SSPCLKIN edge and the word as it would look after this bit shifts in
  always_comb begin
    fall = clkin_q & ~SSPCLKIN;
    word = {shreg_q[DATA_WIDTH-2:0], SSPRXD};
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rx_data_d    = rx_data_q;
    clkin_d      = SSPCLKIN;
    rx_write_d   = 1'b0;
    rx_overrun_d = 1'b0;

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (SSPFSSIN) begin
            state_d   = RECV;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
        RECV: begin
          shreg_d   = word;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            // FSS seen on the last bit starts the next frame without an idle edge
            bit_cnt_d = '0;
            shreg_d   = '0;
            state_d   = SSPFSSIN ? RECV : IDLE;
            if (RxFull) begin
              rx_overrun_d = 1'b1;
            end else begin
              rx_write_d = 1'b1;
              rx_data_d  = word;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    rx_busy_d = (state_d == RECV);
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      clkin_q      <= 1'b0;
      rx_write_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      clkin_q      <= clkin_d;
      rx_write_q   <= rx_write_d;
      rx_overrun_q <= rx_overrun_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign RxData    = rx_data_q;
  assign RxWrite   = rx_write_q;
  assign RxOverrun = rx_overrun_q;
  assign RxBusy    = rx_busy_q;

endmodule

// File: doc/ssp_rx_logic.md
# ssp_rx_logic

Receive-side serial engine of the SSP controller: deserialises Texas Instruments synchronous-serial frames arriving on SSPRXD, clocked by SSPCLKIN and framed by SSPFSSIN, and pushes each completed word into the RX FIFO. It is the counterpart of the transmit path that drives SSPCLKOUT (PCLK/2), SSPFSSOUT and SSPTXD. The serial inputs are generated synchronously to PCLK (same-clock peer or loopback), so no synchroniser is used. Clock edges on SSPCLKIN are detected in the PCLK domain.

## Interface
- DATA_WIDTH, 8, frame length in bits and width of RxData (legal 4..16)
- PCLK  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- SSPCLKIN  input  1  serial clock from peer; data sampled on its falling edge
- SSPFSSIN  input  1  frame sync; high for one SSPCLKIN period before the MSB
- SSPRXD  input  1  serial data, MSB first
- RxFull  input  1  RX FIFO full flag
- RxData  output  DATA_WIDTH  last received word
- RxWrite  output  1  one-PCLK write strobe into the RX FIFO
- RxOverrun  output  1  one-PCLK pulse: word completed while RxFull=1, word dropped
- RxBusy  output  1  high while a frame is in progress (state RECV)

## Operation
- Edge detect: clkin_q <= SSPCLKIN each PCLK. fall = clkin_q & ~SSPCLKIN. A "sampling edge" is a PCLK rising edge at which fall=1. SSPRXD and SSPFSSIN are captured only at sampling edges.
- State IDLE: a sampling edge with SSPFSSIN=1 -> RECV, bit_cnt=0, shift register cleared. SSPFSSIN=0 -> stay IDLE.
- State RECV: each sampling edge shifts in SSPRXD: shreg <= {shreg[DATA_WIDTH-2:0], SSPRXD}, bit_cnt++.
- Completion is the sampling edge where bit_cnt = DATA_WIDTH-1 (the last bit). At that edge:
  - If RxFull=0: RxData <= completed word and RxWrite <= 1.
  - If RxFull=1: RxOverrun <= 1, RxData unchanged, no write.
  - The FSS value captured at that same edge decides the next state. SSPFSSIN=1 -> stay RECV with bit_cnt=0 (back-to-back frame). SSPFSSIN=0 -> IDLE.
- SSPFSSIN during bits 1..DATA_WIDTH-1 is ignored. A mid-frame FSS pulse neither restarts nor aborts the frame.
- RxWrite and RxOverrun are forced to 0 on every cycle they are not set as above. They are never both 1.
- No sampling edges (SSPCLKIN static) -> all state frozen. A frame stalled mid-way stays in RECV indefinitely.
- bit_cnt width is clog2(DATA_WIDTH). It never exceeds DATA_WIDTH-1.

## Timing
- Reset: state=IDLE, bit_cnt=0, shreg=0, clkin_q=0, RxData=0, RxWrite=0, RxOverrun=0, RxBusy=0. All take effect at the first PCLK edge with reset=1.
- Reset mid-frame discards the partial word with no write or overrun. The next frame requires a fresh FSS.
- With SSPCLKIN = PCLK/2, sampling edges occur every 2 PCLK cycles.
  - The frame is FSS edge E0, then data edges E1..E_DATA_WIDTH.
  - The minimum frame is DATA_WIDTH+1 SSPCLKIN periods.
- Latency: RxWrite/RxOverrun high, and RxData valid, during the single PCLK cycle immediately after E_DATA_WIDTH.
- RxData holds its value until the next successful write.
- RxFull is sampled only at the completion edge. Changes at other times have no effect.
- RxBusy = 1 from the cycle after E0 until the cycle after the final completion edge of a non-back-to-back frame.

## Test plan
- Single frame: reset 2 cycles, drive SSPCLKIN=PCLK/2, FSS at E0, bits 0xA5 at E1..E8, RxFull=0.
  - Required: RxData=0xA5, RxWrite high exactly 1 cycle, the cycle after E8. RxBusy falls at the same time. RxOverrun stays 0.
- Back-to-back: FSS=1 at E8 of frame 0x3C, then bits of 0xC3.
  - Required: two RxWrite pulses 16 PCLK apart, with RxData=0x3C then 0xC3.
- Overrun: RxFull=1 at completion of 0x5A after a prior 0x11.
  - Required: RxOverrun 1-cycle pulse, no RxWrite, RxData stays 0x11.
- Reset mid-frame: reset asserted after 4 bits of 0xF0, then a clean frame 0xFF.
  - Required: exactly one RxWrite, with RxData=0xFF.
- FSS glitch: FSS=1 at E3 of frame 0x81.
  - Required: a single RxWrite with 0x81 after E8, no restart.
- Idle: FSS toggled with SSPCLKIN held at 0 or 1 for 50 cycles.
  - Required: no RxWrite, RxBusy=0, RxData unchanged.
